// File: rtl/xorshift_dice_display_pkg.sv
// Shared definitions for the xorshift dice display.
// Mode encodings, shift constants and the xorshift32 step.
package xorshift_dice_display_pkg;

  typedef enum logic [1:0] {
    MODE_FREE = 2'b00,
    MODE_HOLD = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int XS_A = 13;
  localparam int XS_B = 17;
  localparam int XS_C = 5;

  function automatic logic [31:0] xorshift32_next(
    input logic [31:0] x
  );
    logic [31:0] y;
    y = x;
    y = y ^ (y << XS_A);
    y = y ^ (y >> XS_B);
    y = y ^ (y << XS_C);
    return y;
  endfunction

endpackage

// File: rtl/xorshift_dice_display_seg7.sv
// Hex seven-segment decoder, active-high.
// segments[0]=a ... segments[6]=g.
module seg7 (
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h00;
    unique case (digit)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
    endcase
  end

endmodule

// File: rtl/xorshift_dice_display.sv
// Multi-digit xorshift dice on seven-segment displays.
// Free-run tick, edge-triggered step, or hold; seed reload wins.
module xorshift_dice_display
  import xorshift_dice_display_pkg::*;
#(
  parameter int          MAX_COUNT    = 1000,
  parameter int          NUM_DIGITS   = 2,
  parameter int          DIGIT_W      = 3,
  parameter int          SEED_W       = 6,
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001,
  parameter int          CNT_W        = $clog2(MAX_COUNT + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    seed_load,
  input  logic [SEED_W-1:0]       seed,
  input  logic [1:0]              mode,
  input  logic                    step,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [7*NUM_DIGITS-1:0] segments,
  output logic                    digit_valid,
  output logic [7:0]              roll_count
);

  logic [31:0]             state;
  logic [31:0]             nxt;
  logic [31:0]             seed_ext;
  logic [CNT_W-1:0]        counter;
  logic                    step_q;
  logic                    tick;
  logic                    stepped;
  logic                    adv;
  logic [4*NUM_DIGITS-1:0] nd;

  assign seed_ext = 32'(seed);
  assign nxt      = xorshift32_next(state);

  assign tick    = (mode == MODE_FREE) &&
                   (counter == CNT_W'(MAX_COUNT));
  assign stepped = (mode == MODE_STEP) && step && !step_q;
  assign adv     = !seed_load && (tick || stepped);

  always_comb begin
    nd = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      nd[4*i +: DIGIT_W] = nxt[i*DIGIT_W +: DIGIT_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEED_DEFAULT;
      counter     <= '0;
      digits      <= '0;
      digit_valid <= 1'b0;
      roll_count  <= 8'd0;
      step_q      <= 1'b0;
    end else begin
      step_q <= step;
      if (seed_load) begin
        // A zero state would lock xorshift at zero forever.
        state       <= (seed_ext == 32'd0) ? SEED_DEFAULT
                                           : seed_ext;
        counter     <= '0;
        digits      <= '0;
        digit_valid <= 1'b0;
        roll_count  <= 8'd0;
      end else begin
        digit_valid <= adv;
        if (mode == MODE_FREE)
          counter <= tick ? '0 : counter + CNT_W'(1);
        else if (mode == MODE_STEP)
          counter <= '0;
        if (adv) begin
          state      <= nxt;
          digits     <= nd;
          roll_count <= roll_count + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    seg7 u_seg7 (
      .digit    (digits[4*g +: 4]),
      .segments (segments[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_xorshift_dice_display.sv
// Self-checking bench for xorshift_dice_display.
// Directed test-plan steps, then a randomized run against a model.
module tb_xorshift_dice_display;

  localparam int MAXC = 4;
  localparam int ND   = 2;
  localparam int DW   = 3;
  localparam int SW   = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          seed_load;
  logic [SW-1:0] seed;
  logic [1:0]    mode;
  logic          step;
  logic [4*ND-1:0] digits;
  logic [7*ND-1:0] segments;
  logic          digit_valid;
  logic [7:0]    roll_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  longint unsigned m_state;
  int              m_cnt;
  int              m_roll;
  bit              m_valid;
  bit              m_stepq;
  int              m_dig[ND];

  xorshift_dice_display #(
    .MAX_COUNT    (MAXC),
    .NUM_DIGITS   (ND),
    .DIGIT_W      (DW),
    .SEED_W       (SW),
    .SEED_DEFAULT (32'h0000_0001)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seed_load   (seed_load),
    .seed        (seed),
    .mode        (mode),
    .step        (step),
    .digits      (digits),
    .segments    (segments),
    .digit_valid (digit_valid),
    .roll_count  (roll_count)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned ref_next(longint unsigned x);
    longint unsigned m;
    m = 64'h0000_0000_FFFF_FFFF;
    x = (x ^ (x * 8192)) & m;
    x = (x ^ (x / 131072)) & m;
    x = (x ^ (x * 32)) & m;
    return x;
  endfunction

  function automatic logic [6:0] seg_of(int d);
    logic [6:0] t[16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[d];
  endfunction

  task automatic model_reset();
    m_state = 1;
    m_cnt   = 0;
    m_roll  = 0;
    m_valid = 0;
    m_stepq = 0;
    for (int i = 0; i < ND; i++) m_dig[i] = 0;
  endtask

  task automatic model_edge();
    bit adv;
    adv = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (seed_load) begin
      m_state = (seed == 0) ? 1 : longint'(seed);
      m_cnt   = 0;
      m_roll  = 0;
      m_valid = 0;
      for (int i = 0; i < ND; i++) m_dig[i] = 0;
    end else begin
      if (mode == 2'b00) begin
        if (m_cnt == MAXC) begin
          m_cnt = 0;
          adv = 1;
        end else m_cnt++;
      end else if (mode == 2'b10) begin
        m_cnt = 0;
        if (step && !m_stepq) adv = 1;
      end
      m_valid = adv;
      if (adv) begin
        m_state = ref_next(m_state);
        m_roll  = (m_roll + 1) % 256;
        for (int i = 0; i < ND; i++)
          m_dig[i] = int'((m_state >> (i * DW)) % (1 << DW));
      end
    end
    m_stepq = step;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    logic [4*ND-1:0] ed;
    logic [7*ND-1:0] es;
    for (int i = 0; i < ND; i++) begin
      ed[4*i +: 4] = 4'(m_dig[i]);
      es[7*i +: 7] = seg_of(m_dig[i]);
    end
    chk({tag, ".digits"}, 32'(digits), 32'(ed));
    chk({tag, ".segments"}, 32'(segments), 32'(es));
    chk({tag, ".valid"}, 32'(digit_valid), 32'(m_valid));
    chk({tag, ".roll"}, 32'(roll_count), 32'(m_roll));
    chk({tag, ".state"}, dut.state, 32'(m_state));
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    repeat (2) cyc("rst");
    reset_n = 1'b1;
  endtask

  initial begin
    int first;
    reset_n   = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    mode      = 2'b01;
    step      = 1'b0;

    // 1: reset state
    do_reset();
    chk("t1.state", dut.state, 32'h1);
    chk("t1.seg0", 32'(segments), 32'({7'h3F, 7'h3F}));

    // 2: FREE from reset, first tick after MAX_COUNT+1 clocks
    do_reset();
    mode  = 2'b00;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc("t2");
      if (digit_valid && first == 0) first = i;
    end
    chk("t2.first_valid", 32'(first), 32'd5);
    chk("t2.roll", 32'(roll_count), 32'd1);
    chk("t2.digits", 32'(digits), 32'h41);

    // 3: STEP, held step gives one advance per rising edge
    do_reset();
    mode = 2'b10;
    step = 1'b1;
    repeat (10) cyc("t3");
    step = 1'b0;
    repeat (2) cyc("t3");
    step = 1'b1;
    repeat (3) cyc("t3");
    chk("t3.state", dut.state, 32'h0408_0601);
    chk("t3.digits", 32'(digits), 32'h01);
    chk("t3.roll", 32'(roll_count), 32'd2);
    step = 1'b0;

    // 4: zero seed falls back to default seed
    seed_load = 1'b1;
    seed      = '0;
    cyc("t4");
    seed_load = 1'b0;
    chk("t4.state", dut.state, 32'h1);
    step = 1'b1;
    cyc("t4");
    chk("t4.adv", dut.state, 32'h0004_2021);
    step = 1'b0;

    // 5: seed load beats a coincident FREE tick
    mode = 2'b00;
    for (int i = 0; i < 10 && m_cnt != MAXC; i++) cyc("t5");
    chk("t5.cnt_at_max", 32'(dut.counter), 32'(MAXC));
    seed_load = 1'b1;
    seed      = 6'h2A;
    cyc("t5");
    seed_load = 1'b0;
    chk("t5.state", dut.state, 32'h2A);
    chk("t5.valid", 32'(digit_valid), 32'd0);
    chk("t5.cnt", 32'(dut.counter), 32'd0);

    // 6: HOLD freezes counter; resume; async reset mid-count
    repeat (2) cyc("t6");
    chk("t6.cnt2", 32'(dut.counter), 32'd2);
    mode = 2'b01;
    repeat (20) cyc("t6h");
    chk("t6.frozen", 32'(dut.counter), 32'd2);
    mode  = 2'b00;
    first = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc("t6f");
      if (digit_valid && first == 0) first = i;
    end
    chk("t6.resume", 32'(first), 32'd3);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_all("t6.async");
    cyc("t6.inrst");
    reset_n = 1'b1;

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      mode      = 2'($urandom_range(0, 3));
      step      = 1'($urandom_range(0, 1));
      seed_load = ($urandom_range(0, 19) == 0);
      seed      = SW'($urandom);
      if ($urandom_range(0, 2) != 0) mode = 2'b00;
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xorshift_dice_display.md
Name: xorshift_dice_display

Overview:
- Multi-digit pseudo-random "dice" generator driving seven-segment displays.
- Holds a 32-bit xorshift state (shifts 13/17/5) and advances it on a programmable tick, a single-step pulse, or not at all (hold).
- Slices each new state into NUM_DIGITS display digits and decodes every digit through the existing seg7 decoder.
- Successor to the single-digit seven_segment_seconds: adds digit count, digit width, run modes, seed reload and a zero-seed guard.

Parameters:
- MAX_COUNT, 1000: tick period minus one; the free-run counter counts 0..MAX_COUNT, so one tick occurs every MAX_COUNT+1 clocks.
- NUM_DIGITS, 2: number of output digits, 1..8.
- DIGIT_W, 3: state bits per digit, 1..4; NUM_DIGITS*DIGIT_W <= 32.
- SEED_W, 6: width of the seed input, 1..32.
- SEED_DEFAULT, 32'h0000_0001: state loaded at reset and whenever a zero seed is loaded.
- CNT_W, $clog2(MAX_COUNT+1): derived width of the tick counter; not overridden.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- seed_load  in  1  synchronous seed reload, level-sampled each clock.
- seed  in  SEED_W  seed value, zero-extended to 32 bits.
- mode  in  2  run mode: 00 FREE, 01 HOLD, 10 STEP, 11 reserved (behaves as HOLD).
- step  in  1  step request; only its rising edge counts, and only in STEP mode.
- digits  out  4*NUM_DIGITS  registered digit values, digit i at [4i+3:4i].
- segments  out  7*NUM_DIGITS  seg7 encoding of digit i at [7i+6:7i]; combinational from digits.
- digit_valid  out  1  one-cycle pulse, high in the cycle the new digits are first visible.
- roll_count  out  8  number of advances since reset or seed load; wraps 255->0.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=SEED_DEFAULT, counter=0, digits=0, digit_valid=0, roll_count=0, step_q=0.
  - segments show the seg7 pattern for 0 on every digit.
- Advance function: x^=x<<13; x^=x>>17; x^=x<<5, applied in that order, all 32-bit with truncation, as one clock of combinational logic.
- Advance event, on the clock edge:
  - state<=next.
  - digit i <= zero-extended next[i*DIGIT_W +: DIGIT_W].
  - digit_valid<=1 for exactly that next cycle; otherwise 0.
  - roll_count<=roll_count+1.
- Latency: advance condition true at edge N -> new digits and digit_valid visible after edge N.
- FREE mode:
  - counter==MAX_COUNT -> counter<=0 and advance event.
  - otherwise counter<=counter+1.
- HOLD and reserved mode:
  - counter, state and digits are frozen.
  - Returning to FREE resumes counting from the frozen counter value.
- STEP mode:
  - counter is held at 0.
  - step_q<=step every cycle in all modes.
  - step & ~step_q -> advance event.
  - A step held high yields exactly one advance.
- Seed load has priority over any advance in the same cycle:
  - state<= seed zero-extended, or SEED_DEFAULT if that value is 0 (xorshift lock-up guard).
  - counter<=0, digits<=0, roll_count<=0, digit_valid<=0.
  - No advance is issued that cycle.
- Mode change: takes effect the same edge it is sampled; a FREE tick coinciding with the switch to HOLD is dropped.
- Reset mid-operation aborts everything; no partial update occurs.
- DIGIT_W=4: digits range 0..15, displayed as hex by seg7.

Decomposition:
- Shared package contains:
  - mode encodings MODE_FREE/HOLD/STEP;
  - xorshift shift constants 13/17/5;
  - the xorshift32_next function, so other blocks reuse it.
- Instantiate the existing seg7 once per digit through a generate loop.
- No other sub-module is needed; the counter, PRNG register and digit slicer form one process group.

Test Plan:
1. Reset with reset_n=0, then release -> digits=0, digit_valid=0, roll_count=0, state=32'h1.
2. MAX_COUNT=4, FREE from reset -> first digit_valid exactly 5 clocks after release; state=32'h0004_2021; digit0=1, digit1=4 (DIGIT_W=3); roll_count=1.
3. STEP mode; step held high for 10 cycles, then low, then high -> exactly two advances; second state=32'h0408_0601; digit0=1, digit1=0; roll_count=2.
4. seed_load=1 with seed=0 -> state=SEED_DEFAULT; next advance yields state 32'h0004_2021, not stuck at 0.
5. seed_load=1 with seed=6'h2A in the same cycle as a FREE tick -> state=32'h2A, digits=0, no digit_valid; counter restarts at 0.
6. FREE, switch to HOLD at counter=2 for 20 cycles, then back to FREE -> no advance during HOLD; next tick after 3 clocks (MAX_COUNT=4); reset_n pulsed mid-count -> all outputs 0 immediately (asynchronous).
